// File: rtl/imu_accel_spi_reader.sv
// ---------------------------------------------------------------------------
// imu_accel_spi_reader
//
// Configures an ADXL345-class accelerometer over 4-wire SPI (mode 3). It then
// burst-reads X/Y/Z once every SAMPLE_PERIOD clocks and publishes 10-bit
// two's-complement samples with a ReadDone strobe. The downstream low-pass
// filter uses ReadDone as its clock, so Accel* only change in the PUBLISH
// cycle and are stable at both ReadDone edges.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   MISO      in   SPI data from device
//   SCLK      out  SPI clock, idles high
//   MOSI      out  SPI data to device, changes on SCLK falling edges
//   CS_n      out  SPI chip select, active low
//   AccelX/Y/Z out 10-bit samples, right-justified
//   ReadDone  out  high READY_CYCLES clocks after each new sample set
//   InitDone  out  high once device configuration is complete
//   Busy      out  high while CS_n low or during the CS_GAP recovery
// ---------------------------------------------------------------------------
module imu_accel_spi_reader #(
    parameter int CLK_DIV        = 25,
    parameter int SAMPLE_PERIOD  = 5_000_000,
    parameter int STARTUP_CYCLES = 100_000,
    parameter int CS_GAP         = 50,
    parameter int READY_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS_n,
    output logic [9:0] AccelX,
    output logic [9:0] AccelY,
    output logic [9:0] AccelZ,
    output logic       ReadDone,
    output logic       InitDone,
    output logic       Busy
);

    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int START_W = $clog2(STARTUP_CYCLES + 2);
    localparam int TIMER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int GAP_W   = $clog2(CS_GAP + 2);
    localparam int READY_W = $clog2(READY_CYCLES + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [START_W-1:0] START_LAST  = START_W'(STARTUP_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [GAP_W-1:0]   GAP_INIT    = GAP_W'(CS_GAP);
    localparam logic [READY_W-1:0] READY_LAST  = READY_W'(READY_CYCLES - 1);

    // Outgoing frames, left-aligned in the 56-bit transmit shifter.
    localparam logic [55:0] FRAME_FMT  = {2'b00, 6'h31, 8'h00, 40'h0};
    localparam logic [55:0] FRAME_PWR  = {2'b00, 6'h2D, 8'h08, 40'h0};
    localparam logic [55:0] FRAME_READ = {2'b11, 6'h32, 48'h0};

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_CFG_FMT,
        ST_CFG_PWR,
        ST_IDLE,
        ST_READ,
        ST_PUBLISH
    } state_t;

    // Bit-level SPI sequencing; each phase lasts CLK_DIV clocks.
    typedef enum logic [2:0] {
        PH_OFF,
        PH_LEAD,
        PH_LOW,
        PH_HIGH,
        PH_TAIL
    } phase_t;

    state_t              state;
    phase_t              phase;
    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_cnt;
    logic [5:0]          nbits;
    logic [55:0]         tx;
    logic [47:0]         rx;
    logic [START_W-1:0]  startup_cnt;
    logic [TIMER_W-1:0]  timer_cnt;
    logic                tick;
    logic                pending;
    logic [GAP_W-1:0]    gap_cnt;
    logic [READY_W-1:0]  ready_cnt;
    logic                frame_end;

    assign frame_end = (phase == PH_TAIL) && (div_cnt == DIV_LAST);
    assign Busy      = ~CS_n | (gap_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_STARTUP;
            phase       <= PH_OFF;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            nbits       <= '0;
            tx          <= '0;
            rx          <= '0;
            startup_cnt <= '0;
            timer_cnt   <= '0;
            tick        <= 1'b0;
            pending     <= 1'b0;
            gap_cnt     <= '0;
            ready_cnt   <= '0;
            CS_n        <= 1'b1;
            SCLK        <= 1'b1;
            MOSI        <= 1'b0;
            AccelX      <= '0;
            AccelY      <= '0;
            AccelZ      <= '0;
            ReadDone    <= 1'b0;
            InitDone    <= 1'b0;
        end else begin
            if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;

            if (ReadDone) begin
                if (ready_cnt == '0)
                    ReadDone <= 1'b0;
                else
                    ready_cnt <= ready_cnt - 1'b1;
            end

            // Sample timer runs freely once configuration is done.
            tick <= 1'b0;
            if (InitDone) begin
                if (timer_cnt == TIMER_LAST) begin
                    timer_cnt <= '0;
                    tick      <= 1'b1;
                end else begin
                    timer_cnt <= timer_cnt + 1'b1;
                end
            end
            if (tick && Busy)
                pending <= 1'b1;

            // SPI bit engine
            case (phase)
                PH_LEAD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        SCLK    <= 1'b0;
                        MOSI    <= tx[55];
                        tx      <= {tx[54:0], 1'b0};
                        phase   <= PH_LOW;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PH_LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        // Raising SCLK here is the device's sampling edge;
                        // MISO has been stable since the falling edge.
                        div_cnt <= '0;
                        SCLK    <= 1'b1;
                        rx      <= {rx[46:0], MISO};
                        bit_cnt <= bit_cnt + 1'b1;
                        phase   <= PH_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == nbits) begin
                            phase <= PH_TAIL;
                        end else begin
                            SCLK  <= 1'b0;
                            MOSI  <= tx[55];
                            tx    <= {tx[54:0], 1'b0};
                            phase <= PH_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PH_TAIL: begin
                    if (div_cnt == DIV_LAST)
                        div_cnt <= '0;
                    else
                        div_cnt <= div_cnt + 1'b1;
                end
                default: ;
            endcase

            // Transaction starts/ends below override the engine's updates.
            case (state)
                ST_STARTUP: begin
                    if (startup_cnt == START_LAST) begin
                        state   <= ST_CFG_FMT;
                        CS_n    <= 1'b0;
                        phase   <= PH_LEAD;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        nbits   <= 6'd16;
                        tx      <= FRAME_FMT;
                    end else begin
                        startup_cnt <= startup_cnt + 1'b1;
                    end
                end
                ST_CFG_FMT: begin
                    if (frame_end) begin
                        CS_n    <= 1'b1;
                        MOSI    <= 1'b0;
                        phase   <= PH_OFF;
                        gap_cnt <= GAP_INIT;
                        state   <= ST_CFG_PWR;
                    end
                end
                ST_CFG_PWR: begin
                    if (phase == PH_OFF) begin
                        if (gap_cnt == '0) begin
                            CS_n    <= 1'b0;
                            phase   <= PH_LEAD;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                            nbits   <= 6'd16;
                            tx      <= FRAME_PWR;
                        end
                    end else if (frame_end) begin
                        CS_n     <= 1'b1;
                        MOSI     <= 1'b0;
                        phase    <= PH_OFF;
                        gap_cnt  <= GAP_INIT;
                        InitDone <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // Not Busy here, so a tick in this cycle cannot also set pending.
                    if ((tick || pending) && gap_cnt == '0) begin
                        pending <= 1'b0;
                        CS_n    <= 1'b0;
                        phase   <= PH_LEAD;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        nbits   <= 6'd56;
                        tx      <= FRAME_READ;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (frame_end) begin
                        CS_n    <= 1'b1;
                        MOSI    <= 1'b0;
                        phase   <= PH_OFF;
                        gap_cnt <= GAP_INIT;
                        // Received bytes X0,X1,Y0,Y1,Z0,Z1 from MSB down.
                        AccelX  <= {rx[33:32], rx[47:40]};
                        AccelY  <= {rx[17:16], rx[31:24]};
                        AccelZ  <= {rx[1:0],   rx[15:8]};
                        state   <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    ReadDone  <= 1'b1;
                    ready_cnt <= READY_LAST;
                    state     <= ST_IDLE;
                end
                default: state <= ST_STARTUP;
            endcase
        end
    end

endmodule

// File: tb/tb_imu_accel_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_imu_accel_spi_reader
//
// Directed bench for imu_accel_spi_reader with a behavioural mode-3 SPI slave
// that records every CS frame and replays a programmable 48-bit response.
// ---------------------------------------------------------------------------
module tb_imu_accel_spi_reader;

    localparam int CLK_DIV        = 2;
    localparam int SAMPLE_PERIOD  = 400;
    localparam int STARTUP_CYCLES = 20;
    localparam int CS_GAP         = 4;
    localparam int READY_CYCLES   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       MISO = 1'b0;
    logic       SCLK, MOSI, CS_n;
    logic [9:0] AccelX, AccelY, AccelZ;
    logic       ReadDone, InitDone, Busy;

    always #5 clk = ~clk;

    imu_accel_spi_reader #(
        .CLK_DIV        (CLK_DIV),
        .SAMPLE_PERIOD  (SAMPLE_PERIOD),
        .STARTUP_CYCLES (STARTUP_CYCLES),
        .CS_GAP         (CS_GAP),
        .READY_CYCLES   (READY_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MISO     (MISO),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .CS_n     (CS_n),
        .AccelX   (AccelX),
        .AccelY   (AccelY),
        .AccelZ   (AccelZ),
        .ReadDone (ReadDone),
        .InitDone (InitDone),
        .Busy     (Busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // ---------------- SPI slave model ----------------
    logic [55:0] resp = {8'h00, 48'h34FE_FF03_0002};
    logic [55:0] mosi_sh = '0;
    int          fall_cnt = 0;
    int          rise_cnt = 0;
    int          frame_count = 0;
    logic [55:0] frame_val [0:63];
    int          frame_len [0:63];
    int          stray = 0;
    logic        count_stray = 1'b0;

    always @(negedge CS_n) begin
        fall_cnt = 0;
        rise_cnt = 0;
        mosi_sh  = '0;
    end

    always @(negedge SCLK) begin
        if (CS_n === 1'b0 && fall_cnt < 56) begin
            MISO = resp[55 - fall_cnt];
            fall_cnt++;
        end
    end

    always @(posedge SCLK) begin
        if (CS_n === 1'b0) begin
            mosi_sh = {mosi_sh[54:0], MOSI};
            rise_cnt++;
        end
    end

    always @(posedge CS_n) begin
        if (frame_count < 64) begin
            frame_val[frame_count] = mosi_sh;
            frame_len[frame_count] = rise_cnt;
            frame_count++;
        end
    end

    always @(SCLK) begin
        if (count_stray && CS_n === 1'b1)
            stray++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fbase;
        int t_init;
        int t_rd;
        int t_rd2;
        int t_prev;
        int t_now;
        int chg;
        int nz;

        // ---------------- reset values ----------------
        repeat (5) step();
        check("rst_cs_n",     CS_n,     1'b1);
        check("rst_sclk",     SCLK,     1'b1);
        check("rst_mosi",     MOSI,     1'b0);
        check("rst_accelx",   AccelX,   10'h000);
        check("rst_accely",   AccelY,   10'h000);
        check("rst_accelz",   AccelZ,   10'h000);
        check("rst_readdone", ReadDone, 1'b0);
        check("rst_initdone", InitDone, 1'b0);
        check("rst_busy",     Busy,     1'b0);
        fbase = frame_count;
        @(negedge clk) reset = 1'b0;

        // ---------------- startup hold-off ----------------
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (CS_n !== 1'b1) break;
            n++;
        end
        check("startup_cs_high", n, 20);

        // ---------------- configuration ----------------
        for (int i = 0; i < 500 && frame_count < fbase + 1; i++) step();
        check("cfg1_frames",   frame_count - fbase, 1);
        check("cfg1_initdone", InitDone, 1'b0);
        check("cfg1_len",      frame_len[fbase], 16);
        check("cfg1_val",      frame_val[fbase][15:0], 16'h3100);

        for (int i = 0; i < 500 && InitDone !== 1'b1; i++) step();
        t_init = cyc;
        check("init_rise",     InitDone, 1'b1);
        check("cfg2_frames",   frame_count - fbase, 2);
        check("cfg2_len",      frame_len[fbase + 1], 16);
        check("cfg2_val",      frame_val[fbase + 1][15:0], 16'h2D08);
        check("init_readdone", ReadDone, 1'b0);

        // ---------------- first read ----------------
        for (int i = 0; i < 1000 && ReadDone !== 1'b1; i++) step();
        t_rd = cyc;
        check("rd1_latency", t_rd - t_init, 630);
        check("rd1_accelx",  AccelX, 10'h234);
        check("rd1_accely",  AccelY, 10'h3FF);
        check("rd1_accelz",  AccelZ, 10'h200);
        check("rd1_len",     frame_len[fbase + 2], 56);
        check("rd1_cmd",     frame_val[fbase + 2][55:48], 8'hF2);
        check("rd1_busy_t1", Busy, 1'b1);
        repeat (2) step();
        check("rd1_done_t3", ReadDone, 1'b1);
        check("rd1_busy_t3", Busy, 1'b1);
        step();
        check("rd1_done_t4", ReadDone, 1'b1);
        check("rd1_busy_t4", Busy, 1'b0);
        step();
        check("rd1_done_t5", ReadDone, 1'b0);

        // ---------------- second read: hold/update timing ----------------
        // 01 00 80 01 FF 02 -> X=0x001, Y=0x180, Z=0x2FF
        resp = {8'h00, 48'h0100_8001_FF02};
        chg = -1;
        t_rd2 = -1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (chg < 0 && (AccelX !== 10'h234 || AccelY !== 10'h3FF || AccelZ !== 10'h200))
                chg = cyc;
            if (ReadDone === 1'b1) begin
                t_rd2 = cyc;
                break;
            end
        end
        check("rd2_period",  t_rd2 - t_rd, 400);
        check("rd2_update",  chg, t_rd2 - 1);
        check("rd2_accelx",  AccelX, 10'h001);
        check("rd2_accely",  AccelY, 10'h180);
        check("rd2_accelz",  AccelZ, 10'h2FF);

        // ---------------- steady-state cadence ----------------
        count_stray = 1'b1;
        t_prev = t_rd2;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20 && ReadDone !== 1'b0; i++) step();
            for (int i = 0; i < 1000 && ReadDone !== 1'b1; i++) step();
            t_now = cyc;
            check("steady_period", t_now - t_prev, 400);
            t_prev = t_now;
        end
        check("steady_stray_sclk", stray, 0);
        count_stray = 1'b0;

        // ---------------- reset in the middle of a read ----------------
        for (int i = 0; i < 1000 && CS_n !== 1'b0; i++) step();
        for (int i = 0; i < 500 && rise_cnt < 28; i++) step();
        check("midrd_bits", rise_cnt, 28);
        @(negedge clk) reset = 1'b1;
        step();
        check("midrd_cs_n",   CS_n,   1'b1);
        check("midrd_sclk",   SCLK,   1'b1);
        check("midrd_mosi",   MOSI,   1'b0);
        check("midrd_busy",   Busy,   1'b0);
        check("midrd_accelx", AccelX, 10'h000);
        @(negedge clk) reset = 1'b0;
        fbase = frame_count;

        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (CS_n !== 1'b1) break;
            n++;
        end
        check("restart_cs_high", n, 20);

        for (int i = 0; i < 500 && InitDone !== 1'b1; i++) step();
        t_init = cyc;
        check("restart_frames",  frame_count - fbase, 2);
        check("restart_cfg1",    frame_val[fbase][15:0], 16'h3100);
        check("restart_cfg2",    frame_val[fbase + 1][15:0], 16'h2D08);
        check("restart_accely",  AccelY, 10'h000);

        nz = 0;
        for (int i = 0; i < 1000 && ReadDone !== 1'b1; i++) begin
            step();
            if (AccelX !== 10'h000 || AccelY !== 10'h000 || AccelZ !== 10'h000)
                nz++;
        end
        check("restart_latency",   cyc - t_init, 630);
        check("restart_nonzero",   nz, 2);
        check("restart_accelz",    AccelZ, 10'h2FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
